// File: rtl/lbm_solve_sequencer.sv
// Avalon-MM controlled sequencer that launches NSTEPS solver steps, times the run
// in clock cycles and aborts on command or when a single step exceeds TIMEOUT cycles.
module lbm_solve_sequencer #(
  parameter int unsigned TIMEOUT = 1048576
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        step_start,
  input  logic        step_done,
  output logic [31:0] solve_time,
  output logic        irq
);

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_NSTEPS = 2'd2;
  localparam logic [1:0] ADDR_STIME  = 2'd3;

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FIN
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_irq_en;
  logic              r_done;
  logic              r_aborted;
  logic              r_timeout;
  logic [31:0]       r_nsteps;
  logic [31:0]       r_solve_time;
  logic [31:0]       r_cycle;
  logic [31:0]       r_step_cnt;
  logic [WD_W-1:0]   r_wd;

  logic              w_busy;
  logic              w_ctrl_wr;
  logic              w_status_wr;
  logic              w_nsteps_wr;
  logic              w_go_req;
  logic              w_abort_req;
  logic [31:0]       w_cycle_sat;
  logic [31:0]       w_step_cnt_inc;
  logic [WD_W-1:0]   w_wd_inc;

  logic              w_go;
  logic              w_abort;
  logic              w_tmo;
  logic              w_step;
  logic              w_fin;
  logic              w_wd_clr;
  logic              w_wd_inc_en;

  assign w_busy      = (r_state != S_IDLE);
  assign w_ctrl_wr   = write && (address == ADDR_CTRL);
  assign w_status_wr = write && (address == ADDR_STATUS);
  assign w_nsteps_wr = write && (address == ADDR_NSTEPS);
  assign w_go_req    = w_ctrl_wr && writedata[0] && !writedata[1];
  assign w_abort_req = w_ctrl_wr && writedata[1];

  // Counter value including the current cycle, so every capture reports whole run length.
  assign w_cycle_sat    = (&r_cycle) ? r_cycle : r_cycle + 32'd1;
  assign w_step_cnt_inc = r_step_cnt + 32'd1;
  assign w_wd_inc       = r_wd + 1'b1;

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    step_start  = 1'b0;
    w_go        = 1'b0;
    w_abort     = 1'b0;
    w_tmo       = 1'b0;
    w_step      = 1'b0;
    w_fin       = 1'b0;
    w_wd_clr    = 1'b0;
    w_wd_inc_en = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_go_req) begin
          w_go        = 1'b1;
          w_state_nxt = (r_nsteps == '0) ? S_FIN : S_ISSUE;
        end
      end
      S_ISSUE: begin
        step_start  = 1'b1;
        w_wd_clr    = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (step_done) begin
          w_step      = 1'b1;
          w_state_nxt = (w_step_cnt_inc == r_nsteps) ? S_FIN : S_ISSUE;
        end else if (w_wd_inc == WD_LIMIT) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_wd_inc_en = 1'b1;
        end
      end
      S_FIN: begin
        w_fin       = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // A host abort overrides any step completion, timeout or finish in the same cycle.
    if (w_busy && w_abort_req) begin
      w_abort     = 1'b1;
      w_step      = 1'b0;
      w_tmo       = 1'b0;
      w_fin       = 1'b0;
      w_wd_inc_en = 1'b0;
      w_state_nxt = S_IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_irq_en     <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_timeout    <= 1'b0;
      r_nsteps     <= '0;
      r_solve_time <= '0;
      r_cycle      <= '0;
      r_step_cnt   <= '0;
      r_wd         <= '0;
      readdata     <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (w_ctrl_wr)
        r_irq_en <= writedata[2];

      if (w_nsteps_wr && !w_busy)
        r_nsteps <= writedata;

      if (w_go)
        r_cycle <= '0;
      else if (w_busy)
        r_cycle <= w_cycle_sat;

      if (w_go)
        r_step_cnt <= '0;
      else if (w_step)
        r_step_cnt <= w_step_cnt_inc;

      if (w_wd_clr)
        r_wd <= '0;
      else if (w_wd_inc_en)
        r_wd <= w_wd_inc;

      // Later assignments win, so a set beats a same-cycle STATUS clear.
      if (w_go) begin
        r_done    <= 1'b0;
        r_aborted <= 1'b0;
        r_timeout <= 1'b0;
      end else begin
        if (w_status_wr) begin
          r_done    <= 1'b0;
          r_aborted <= 1'b0;
          r_timeout <= 1'b0;
        end
        if (w_fin)
          r_done <= 1'b1;
        if (w_abort || w_tmo)
          r_aborted <= 1'b1;
        if (w_tmo)
          r_timeout <= 1'b1;
      end

      if (w_fin || w_abort || w_tmo)
        r_solve_time <= w_cycle_sat;

      case (address)
        ADDR_CTRL:   readdata <= {29'b0, r_irq_en, 2'b0};
        ADDR_STATUS: readdata <= {28'b0, r_timeout, r_aborted, r_done, w_busy};
        ADDR_NSTEPS: readdata <= r_nsteps;
        ADDR_STIME:  readdata <= r_solve_time;
        default:     readdata <= '0;
      endcase
    end
  end

  assign solve_time = r_solve_time;
  assign irq        = r_irq_en & (r_done | r_aborted);

endmodule
